// File: rtl/ofb_stream_ctrl.sv
// OFB AES-128 stream controller: sequences an external combinational core one block at a time,
// holding key, feedback and plaintext stable while the core settles over a multicycle path.
module ofb_stream_ctrl #(
    parameter int CORE_LATENCY = 4,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [127:0]     key_in,
    input  logic [127:0]     iv_in,
    input  logic [CNT_W-1:0] num_blocks,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out_data,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] blk_idx,
    output logic [127:0]     core_key,
    output logic [127:0]     core_iv,
    output logic [127:0]     core_image,
    input  logic [127:0]     core_ciphertext,
    input  logic [127:0]     core_pre_enc
);

    typedef enum logic [1:0] {
        IDLE,
        ACCEPT,
        CALC,
        EMIT
    } state_t;

    localparam logic [3:0] SETTLE_INIT = 4'(CORE_LATENCY - 1);

    state_t             state_q, state_d;
    logic [127:0]       key_q, key_d;
    logic [127:0]       fb_q, fb_d;
    logic [127:0]       pt_q, pt_d;
    logic [127:0]       out_data_q, out_data_d;
    logic [CNT_W-1:0]   remain_q, remain_d;
    logic [CNT_W-1:0]   blk_idx_q, blk_idx_d;
    logic [3:0]         settle_q, settle_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign blk_idx    = blk_idx_q;
    assign core_key   = key_q;
    assign core_iv    = fb_q;
    assign core_image = pt_q;

    always_comb begin
        state_d    = state_q;
        key_d      = key_q;
        fb_d       = fb_q;
        pt_d       = pt_q;
        out_data_d = out_data_q;
        remain_d   = remain_q;
        blk_idx_d  = blk_idx_q;
        settle_d   = settle_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    key_d     = key_in;
                    fb_d      = iv_in;
                    remain_d  = num_blocks;
                    blk_idx_d = '0;
                    if (num_blocks == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ACCEPT;
                    end
                end
            end
            ACCEPT: begin
                if (in_valid) begin
                    pt_d     = in_data;
                    settle_d = SETTLE_INIT;
                    state_d  = CALC;
                end
            end
            CALC: begin
                // The keystream becomes the next feedback value only here, once the core has settled.
                if (settle_q == 4'd0) begin
                    out_data_d = core_ciphertext;
                    fb_d       = core_pre_enc;
                    remain_d   = remain_q - CNT_W'(1);
                    state_d    = EMIT;
                end else begin
                    settle_d = settle_q - 4'd1;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    if (remain_q == '0) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        blk_idx_d = blk_idx_q + CNT_W'(1);
                        state_d   = ACCEPT;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d  = (state_d == ACCEPT);
        out_valid_d = (state_d == EMIT);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            key_q       <= '0;
            fb_q        <= '0;
            pt_q        <= '0;
            out_data_q  <= '0;
            remain_q    <= '0;
            blk_idx_q   <= '0;
            settle_q    <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            fb_q        <= fb_d;
            pt_q        <= pt_d;
            out_data_q  <= out_data_d;
            remain_q    <= remain_d;
            blk_idx_q   <= blk_idx_d;
            settle_q    <= settle_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: tb/tb_ofb_stream_ctrl.sv
// Directed bench for ofb_stream_ctrl at CORE_LATENCY 4, 1 and 15, each driving a core model that
// returns SP800-38A OFB keystream only once its inputs have been stable for the allowed settle time.
module tb_ofb_stream_ctrl;

    localparam logic [127:0] KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] IV   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KEY2 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] IV2  = 128'hf0e0d0c0b0a090807060504030201000;
    localparam logic [127:0] KS1  = 128'h50fe67cc996d32b6da0937e99bafec60;
    localparam logic [127:0] KS2  = 128'hd9a4dada0892239f6b8b3d7680e15674;
    localparam logic [127:0] KS3  = 128'ha78819583f0308e7a6bf36b1386abf23;
    localparam logic [127:0] KS4  = 128'hc6d3416d29165c6fcb8e51a227ba994e;
    localparam logic [127:0] P1   = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] P2   = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] P3   = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
    localparam logic [127:0] P4   = 128'hf69f2445df4f9b17ad2b417be66c3710;
    localparam logic [127:0] C1   = 128'h3b3fd92eb72dad20333449f8e83cfb4a;
    localparam logic [127:0] C2   = 128'h7789508d16918f03f53c52dac54ed825;
    localparam logic [127:0] C3   = 128'h9740051e9c5fecf64344f7a82260edcc;
    localparam logic [127:0] C4   = 128'h304c6528f659c77866a510d9c1d6ae5e;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    logic         start      [3];
    logic [127:0] key_in     [3];
    logic [127:0] iv_in      [3];
    logic [127:0] in_data    [3];
    logic [15:0]  num_blocks [3];
    logic         in_valid   [3];
    logic         out_ready  [3];

    wire          in_ready   [3];
    wire          out_valid  [3];
    wire          busy       [3];
    wire          done       [3];
    wire [15:0]   blk_idx    [3];
    wire [127:0]  out_data   [3];
    wire [127:0]  core_key   [3];
    wire [127:0]  core_iv    [3];
    wire [127:0]  core_image [3];
    wire [127:0]  core_ct    [3];
    wire [127:0]  core_pe    [3];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat_of(input int i);
        return (i == 0) ? 4 : (i == 1) ? 1 : 15;
    endfunction

    // Known AES-128 chain for the SP800-38A key; anything else gets an arbitrary but fixed mix.
    function automatic logic [127:0] keystream(input logic [127:0] k, input logic [127:0] v);
        if (k == KEY) begin
            if (v == IV)  return KS1;
            if (v == KS1) return KS2;
            if (v == KS2) return KS3;
            if (v == KS3) return KS4;
        end
        return v ^ {v[63:0], v[127:64]} ^ k ^ 128'h0123456789abcdeffedcba9876543210;
    endfunction

    function automatic logic [127:0] junk();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int LAT = (g == 0) ? 4 : (g == 1) ? 1 : 15;
        logic [383:0] snap = '0;
        logic [4:0]   age  = '0;
        wire  [383:0] cur  = {core_key[g], core_iv[g], core_image[g]};
        wire  [4:0]   eff_age = (cur != snap) ? 5'd0 : age;
        wire          settled = (eff_age >= 5'(LAT - 1));
        wire  [127:0] ks = keystream(core_key[g], core_iv[g]);

        // Until settled the model drives a corrupted result, so an early capture is visible.
        assign core_pe[g] = settled ? ks : ~ks;
        assign core_ct[g] = settled ? (core_image[g] ^ ks) : ~(core_image[g] ^ ks);

        always @(posedge clk) begin
            if (cur != snap) begin
                snap <= cur;
                age  <= 5'd1;
            end else if (age != 5'd31) begin
                age <= age + 5'd1;
            end
        end

        ofb_stream_ctrl #(
            .CORE_LATENCY(LAT),
            .CNT_W(16)
        ) u_dut (
            .clk(clk),
            .rst(rst),
            .start(start[g]),
            .key_in(key_in[g]),
            .iv_in(iv_in[g]),
            .num_blocks(num_blocks[g]),
            .in_valid(in_valid[g]),
            .in_ready(in_ready[g]),
            .in_data(in_data[g]),
            .out_valid(out_valid[g]),
            .out_ready(out_ready[g]),
            .out_data(out_data[g]),
            .busy(busy[g]),
            .done(done[g]),
            .blk_idx(blk_idx[g]),
            .core_key(core_key[g]),
            .core_iv(core_iv[g]),
            .core_image(core_image[g]),
            .core_ciphertext(core_ct[g]),
            .core_pre_enc(core_pe[g])
        );
    end

    task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic apply_start(input int i, input logic [127:0] k, input logic [127:0] v,
                               input logic [15:0] n);
        start[i]      = 1'b1;
        key_in[i]     = k;
        iv_in[i]      = v;
        num_blocks[i] = n;
        @(negedge clk);
        start[i]      = 1'b0;
        key_in[i]     = junk();
        iv_in[i]      = junk();
        num_blocks[i] = 16'($urandom);
    endtask

    // One block through the handshake; in_valid is toggled with junk whenever it must not be consumed.
    task automatic apply_block(input int i, input logic [127:0] pt, input logic [127:0] exp,
                               input int stall, input int bp, input string tag);
        int   n;
        int   h;
        logic stable;
        n = 0;
        while (in_ready[i] !== 1'b1 && n < 64) begin
            in_valid[i] = 1'($urandom_range(1));
            in_data[i]  = junk();
            @(negedge clk);
            n++;
        end
        check_output({tag, " in_ready"}, 128'(in_ready[i]), 128'(1));
        in_valid[i] = 1'b0;
        for (int s = 0; s < stall; s++) @(negedge clk);
        in_valid[i] = 1'b1;
        in_data[i]  = pt;
        h = cyc;
        @(negedge clk);
        in_valid[i] = 1'b0;
        in_data[i]  = junk();
        n = 0;
        while (out_valid[i] !== 1'b1 && n < 64) begin
            in_valid[i] = 1'($urandom_range(1));
            @(negedge clk);
            n++;
        end
        check_output({tag, " latency"}, 128'(cyc - h), 128'(lat_of(i) + 1));
        check_output({tag, " out_data"}, out_data[i], exp);
        if (bp > 0) begin
            stable = 1'b1;
            for (int s = 0; s < bp; s++) begin
                in_valid[i] = 1'b1;
                @(negedge clk);
                if (out_valid[i] !== 1'b1 || out_data[i] !== exp || in_ready[i] !== 1'b0) stable = 1'b0;
            end
            check_output({tag, " backpressure stable"}, 128'(stable), 128'(1));
        end
        in_valid[i]  = 1'b0;
        out_ready[i] = 1'b1;
        @(negedge clk);
        out_ready[i] = 1'b0;
        check_output({tag, " out_valid drop"}, 128'(out_valid[i]), 128'(0));
    endtask

    task automatic check_done(input int i, input string tag);
        check_output({tag, " done"}, 128'(done[i]), 128'(1));
        check_output({tag, " busy low"}, 128'(busy[i]), 128'(0));
        @(negedge clk);
        check_output({tag, " done single"}, 128'(done[i]), 128'(0));
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            start[i]      = 1'b0;
            key_in[i]     = '0;
            iv_in[i]      = '0;
            in_data[i]    = '0;
            num_blocks[i] = '0;
            in_valid[i]   = 1'b0;
            out_ready[i]  = 1'b0;
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_output("reset busy", 128'(busy[0]), 128'(0));
        check_output("reset in_ready", 128'(in_ready[0]), 128'(0));
        check_output("reset out_valid", 128'(out_valid[0]), 128'(0));
        check_output("reset out_data", out_data[0], 128'(0));
        check_output("reset core_iv", core_iv[0], 128'(0));

        $display("[TB] single block");
        apply_start(0, KEY, IV, 16'd1);
        check_output("t1 busy", 128'(busy[0]), 128'(1));
        check_output("t1 core_key", core_key[0], KEY);
        check_output("t1 core_iv", core_iv[0], IV);
        apply_block(0, P1, C1, 0, 0, "t1 blk0");
        check_done(0, "t1");
        check_output("t1 key held", core_key[0], KEY);

        $display("[TB] two blocks");
        apply_start(0, KEY, IV, 16'd2);
        check_output("t2 blk_idx0", 128'(blk_idx[0]), 128'(0));
        apply_block(0, P1, C1, 1, 0, "t2 blk0");
        check_output("t2 blk_idx1", 128'(blk_idx[0]), 128'(1));
        check_output("t2 core_iv blk1", core_iv[0], KS1);
        apply_block(0, P2, C2, 0, 0, "t2 blk1");
        check_done(0, "t2");

        $display("[TB] backpressure");
        apply_start(0, KEY, IV, 16'd1);
        apply_block(0, P1, C1, 0, 20, "t3 blk0");
        check_done(0, "t3");

        $display("[TB] zero length and ignored start");
        apply_start(0, KEY2, IV2, 16'd0);
        check_output("t4 done", 128'(done[0]), 128'(1));
        check_output("t4 busy", 128'(busy[0]), 128'(0));
        check_output("t4 in_ready", 128'(in_ready[0]), 128'(0));
        check_output("t4 key latched", core_key[0], KEY2);
        @(negedge clk);
        check_output("t4 done single", 128'(done[0]), 128'(0));
        apply_start(0, KEY, IV, 16'd2);
        apply_block(0, P1, C1, 0, 0, "t4 blk0");
        apply_start(0, KEY2, IV2, 16'd7);
        check_output("t4 key kept", core_key[0], KEY);
        check_output("t4 feedback kept", core_iv[0], KS1);
        check_output("t4 blk_idx kept", 128'(blk_idx[0]), 128'(1));
        apply_block(0, P2, C2, 0, 0, "t4 blk1");
        check_done(0, "t4");

        $display("[TB] reset mid-message");
        apply_start(0, KEY, IV, 16'd3);
        apply_block(0, P1, C1, 0, 0, "t5 blk0");
        in_valid[0] = 1'b1;
        in_data[0]  = P2;
        @(negedge clk);
        in_valid[0] = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_output("t5 busy", 128'(busy[0]), 128'(0));
        check_output("t5 in_ready", 128'(in_ready[0]), 128'(0));
        check_output("t5 out_valid", 128'(out_valid[0]), 128'(0));
        check_output("t5 done", 128'(done[0]), 128'(0));
        check_output("t5 out_data", out_data[0], 128'(0));
        check_output("t5 blk_idx", 128'(blk_idx[0]), 128'(0));
        check_output("t5 core_key", core_key[0], 128'(0));
        check_output("t5 core_iv", core_iv[0], 128'(0));
        check_output("t5 core_image", core_image[0], 128'(0));
        @(negedge clk);
        check_output("t5 no done", 128'(done[0]), 128'(0));
        apply_start(0, KEY, IV, 16'd2);
        apply_block(0, P1, C1, 0, 0, "t5 new blk0");
        apply_block(0, P2, C2, 0, 0, "t5 new blk1");
        check_done(0, "t5");

        $display("[TB] input stalls at latency 1 and 15");
        for (int i = 1; i < 3; i++) begin
            apply_start(i, KEY, IV, 16'd4);
            apply_block(i, P1, C1, $urandom_range(3), 0, "t6 blk0");
            apply_block(i, P2, C2, $urandom_range(3), 0, "t6 blk1");
            apply_block(i, P3, C3, $urandom_range(3), 0, "t6 blk2");
            check_output("t6 blk_idx3", 128'(blk_idx[i]), 128'(3));
            apply_block(i, P4, C4, $urandom_range(3), 0, "t6 blk3");
            check_done(i, "t6");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
